// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 command/voice controller.
package jt6295_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CH = 2'd1,
    FETCH   = 2'd2,
    ISSUE   = 2'd3
  } state_t;

  localparam int TBL_BYTES = 8;
  localparam int HDR_BYTES = 6;
  localparam int ATT_W     = 4;
  localparam int GRP_CH    = 4;

endpackage

// File: rtl/jt6295_wrdet.sv
// CPU write detector: latches din while wrn is low and flags the first
// cycle wrn returns high as the decode cycle.
module jt6295_wrdet (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrn,
  input  logic [7:0] din,
  output logic       cmd_stb,
  output logic [7:0] cmd_data
);

  logic wrn_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrn_l    <= 1'b1;
      cmd_data <= 8'h00;
    end else begin
      wrn_l <= wrn;
      if (!wrn) cmd_data <= din;
    end
  end

  assign cmd_stb = wrn & ~wrn_l;

endmodule

// File: rtl/jt6295_vctrl.sv
// MSM6295-style command decoder and voice controller with ROM phrase fetch.
// Optional JT6295_RETRIG_EN: starts to busy channels stop then restart them.
module jt6295_vctrl
  import jt6295_pkg::*;
#(
  parameter int CH = 4,
  parameter int AW = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrn,
  input  logic [7:0]       din,
  input  logic [CH-1:0]    busy,
  output logic [CH-1:0]    start,
  output logic [CH-1:0]    stop,
  output logic [CH*AW-1:0] start_addr,
  output logic [CH*AW-1:0] end_addr,
  output logic [CH*4-1:0]  att,
  output logic             rom_cs,
  output logic [AW-1:0]    rom_addr,
  input  logic [7:0]       rom_data,
  input  logic             rom_ok,
  output logic             cmd_busy
);

  localparam int GW = (CH > GRP_CH) ? 1 : 0;
  localparam int GB = (GW > 0) ? GW : 1;

  state_t          state;
  logic [6:0]      phrase;
  logic [CH-1:0]   sel;
  logic [ATT_W-1:0] att_new;
  logic [2:0]      k;
  logic            settled;
  logic [7:0]      hdr [0:HDR_BYTES-2];
  logic [CH-1:0]   pend;
  logic [GB-1:0]   grp;

  logic            cmd_stb;
  logic [7:0]      cmd_data;

  jt6295_wrdet u_wrdet (
    .clk      (clk),
    .rst      (rst),
    .wrn      (wrn),
    .din      (din),
    .cmd_stb  (cmd_stb),
    .cmd_data (cmd_data)
  );

  function automatic logic [AW-1:0] tbl_addr(input logic [6:0] p, input logic [2:0] idx);
    return AW'(p) * AW'(TBL_BYTES) + AW'(idx);
  endfunction

  logic            is_phrase, is_chan, is_stop, fetch_done, valid;
  logic [GB-1:0]   grp_new;
  logic [7:0]      stop_wide, sel_wide;
  logic [CH-1:0]   stop_req, ch_sel, upd, start_now, stop_issue, pend_next, stop_next;
  logic [23:0]     start_full, end_full;
  logic [AW-1:0]   new_start, new_end;

  // A byte in WAIT_CH is always the channel byte, whatever its top bit.
  always_comb begin
    is_phrase = cmd_stb & cmd_data[7] & (state == IDLE);
    is_chan   = cmd_stb & (state == WAIT_CH);
    is_stop   = cmd_stb & ~cmd_data[7] & (state != WAIT_CH);
    grp_new   = grp;
    if (is_stop) grp_new = (CH > GRP_CH) ? cmd_data[GB-1:0] : '0;
    stop_wide = {4'h0, cmd_data[6:3]} << {grp_new, 2'b00};
    sel_wide  = {4'h0, cmd_data[7:4]} << {grp_new, 2'b00};
    stop_req  = stop_wide[CH-1:0] & {CH{is_stop}};
    ch_sel    = sel_wide[CH-1:0];

    fetch_done = (state == FETCH) && settled && rom_ok && (k == 3'(HDR_BYTES - 1));
    start_full = {hdr[0], hdr[1], hdr[2]};
    end_full   = {hdr[3], hdr[4], rom_data};
    new_start  = start_full[AW-1:0];
    new_end    = end_full[AW-1:0];
    valid      = (new_end >= new_start);

    upd        = '0;
    start_now  = '0;
    stop_issue = '0;
    pend_next  = '0;
    for (int j = 0; j < CH; j++) begin
      if (fetch_done && sel[j] && valid) begin
        if (!busy[j]) begin
          upd[j]       = 1'b1;
          start_now[j] = 1'b1;
        end else begin
`ifdef JT6295_RETRIG_EN
          upd[j]        = 1'b1;
          stop_issue[j] = 1'b1;
          pend_next[j]  = 1'b1;
`endif
        end
      end
    end
    if (state == ISSUE) start_now = start_now | pend;
    stop_next = (stop_req | stop_issue) & ~start_now;
  end

  // Outputs for the ISSUE cycle are registered on the edge that takes the
  // last header byte, so they appear while the FSM sits in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start      <= '0;
      stop       <= '0;
      start_addr <= '0;
      end_addr   <= '0;
      att        <= '0;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      phrase     <= '0;
      sel        <= '0;
      att_new    <= '0;
      k          <= '0;
      settled    <= 1'b0;
      pend       <= '0;
      grp        <= '0;
      for (int i = 0; i < HDR_BYTES - 1; i++) hdr[i] <= 8'h00;
    end else begin
      start <= start_now;
      stop  <= stop_next;
      grp   <= grp_new;
      for (int j = 0; j < CH; j++) begin
        if (upd[j]) begin
          start_addr[j*AW +: AW]      <= new_start;
          end_addr[j*AW +: AW]        <= new_end;
          att[j*ATT_W +: ATT_W]       <= att_new;
        end
      end
      case (state)
        IDLE: begin
          if (is_phrase) begin
            phrase <= cmd_data[6:0];
            state  <= WAIT_CH;
          end
        end
        WAIT_CH: begin
          if (is_chan) begin
            sel      <= ch_sel;
            att_new  <= cmd_data[3:0];
            k        <= 3'd0;
            settled  <= 1'b0;
            rom_cs   <= 1'b1;
            rom_addr <= tbl_addr(phrase, 3'd0);
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!settled) begin
            settled <= 1'b1;
          end else if (rom_ok) begin
            if (k == 3'(HDR_BYTES - 1)) begin
              rom_cs <= 1'b0;
              pend   <= pend_next;
              state  <= ISSUE;
            end else begin
              hdr[k]   <= rom_data;
              k        <= k + 3'd1;
              rom_addr <= tbl_addr(phrase, k + 3'd1);
              settled  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          pend <= '0;
          if (pend == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_busy = (state != IDLE);

endmodule

// File: tb/tb_jt6295_vctrl.sv
// Directed bench for jt6295_vctrl: a CH=4 and a CH=8 instance share the
// CPU bus and ROM contents; expected values are hand-computed.
module tb_jt6295_vctrl;

  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wrn, rom_ok;
  logic [7:0]  din;
  logic [3:0]  busy4, start4, stop4;
  logic [7:0]  busy8, start8, stop8;
  logic [4*AW-1:0] start_addr4, end_addr4;
  logic [8*AW-1:0] start_addr8, end_addr8;
  logic [15:0] att4;
  logic [31:0] att8;
  logic        rom_cs4, rom_cs8, cmd_busy4, cmd_busy8;
  logic [AW-1:0] rom_addr4, rom_addr8;
  logic [7:0]  rom_data4, rom_data8;
  logic [7:0]  rom [0:1023];

  assign rom_data4 = rom[rom_addr4[9:0]];
  assign rom_data8 = rom[rom_addr8[9:0]];

  jt6295_vctrl #(.CH(4), .AW(AW)) u_dut4 (
    .clk(clk), .rst(rst), .wrn(wrn), .din(din), .busy(busy4),
    .start(start4), .stop(stop4), .start_addr(start_addr4), .end_addr(end_addr4),
    .att(att4), .rom_cs(rom_cs4), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .rom_ok(rom_ok), .cmd_busy(cmd_busy4)
  );

  jt6295_vctrl #(.CH(8), .AW(AW)) u_dut8 (
    .clk(clk), .rst(rst), .wrn(wrn), .din(din), .busy(busy8),
    .start(start8), .stop(stop8), .start_addr(start_addr8), .end_addr(end_addr8),
    .att(att8), .rom_cs(rom_cs8), .rom_addr(rom_addr8), .rom_data(rom_data8),
    .rom_ok(rom_ok), .cmd_busy(cmd_busy8)
  );

  int checks = 0;
  int errors = 0;

  int          fsCyc, fpCyc;
  logic [7:0]  fsVal, fs8Val, fpVal, fp8Val;
  logic        anyStop8, romCs1, cbAtStart;
  logic [AW-1:0] romAddr1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU write; returns just after the decode edge (cycle 0).
  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    wrn = 1'b0;
    din = d;
    @(negedge clk);
    wrn = 1'b1;
    @(posedge clk);
  endtask

  // Observes len cycles after a decode edge, recording first start/stop.
  task automatic runWindow(input int len, input bit delayOk);
    fsCyc = 0; fpCyc = 0; fsVal = 0; fs8Val = 0; fpVal = 0; fp8Val = 0;
    anyStop8 = 0; romCs1 = 0; cbAtStart = 0; romAddr1 = '0;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      if (n == 1) begin
        romAddr1 = rom_addr4;
        romCs1   = rom_cs4;
      end
      if (fsCyc == 0 && start4 != 0) begin
        fsCyc = n; fsVal = 8'(start4); fs8Val = start8; cbAtStart = cmd_busy4;
      end
      if (fpCyc == 0 && stop4 != 0) begin
        fpCyc = n; fpVal = 8'(stop4); fp8Val = stop8;
      end
      anyStop8 = anyStop8 | (|stop8);
      rom_ok = !(delayOk && n >= 6 && n <= 8);
    end
    rom_ok = 1'b1;
  endtask

  initial begin
    rst = 1'b1; wrn = 1'b1; din = 8'h00; rom_ok = 1'b1;
    busy4 = '0; busy8 = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    {rom[8'h28], rom[8'h29], rom[8'h2A], rom[8'h2B], rom[8'h2C], rom[8'h2D]} = 48'h00_01_00_00_02_00;
    {rom[8'h08], rom[8'h09], rom[8'h0A], rom[8'h0B], rom[8'h0C], rom[8'h0D]} = 48'h00_00_40_00_00_80;
    {rom[8'h10], rom[8'h11], rom[8'h12], rom[8'h13], rom[8'h14], rom[8'h15]} = 48'h00_03_00_00_02_00;
    {rom[8'h18], rom[8'h19], rom[8'h1A], rom[8'h1B], rom[8'h1C], rom[8'h1D]} = 48'h00_05_00_00_06_00;

    repeat (3) @(negedge clk);
    checkOutput("rst_start", 32'(start4), 0);
    checkOutput("rst_stop", 32'(stop4), 0);
    checkOutput("rst_saddr", 32'(start_addr4[31:0]), 0);
    checkOutput("rst_att", 32'(att4), 0);
    checkOutput("rst_romcs", 32'(rom_cs4), 0);
    checkOutput("rst_romaddr", 32'(rom_addr4), 0);
    checkOutput("rst_cmdbusy", 32'({cmd_busy8, cmd_busy4}), 0);
    rst = 1'b0;

    // Phrase 5 on channel 1, attenuation F
    applyStimulus(8'h85);
    @(negedge clk);
    checkOutput("waitch_busy", 32'(cmd_busy4), 1);
    applyStimulus(8'h2F);
    runWindow(20, 1'b0);
    checkOutput("p5_romcs", 32'(romCs1), 1);
    checkOutput("p5_romaddr", 32'(romAddr1), 32'h28);
    checkOutput("p5_cycle", fsCyc, 13);
    checkOutput("p5_start4", 32'(fsVal), 32'h02);
    checkOutput("p5_start8", 32'(fs8Val), 32'h02);
    checkOutput("p5_busy_issue", 32'(cbAtStart), 1);
    checkOutput("p5_saddr1", 32'(start_addr4[1*AW +: AW]), 32'h00100);
    checkOutput("p5_eaddr1", 32'(end_addr4[1*AW +: AW]), 32'h00200);
    checkOutput("p5_att1", 32'(att4[7:4]), 32'hF);
    checkOutput("p5_idle", 32'(cmd_busy4), 0);

    // Stop all four channels of group 0
    applyStimulus(8'h78);
    runWindow(4, 1'b0);
    checkOutput("stop_cycle", fpCyc, 1);
    checkOutput("stop4_val", 32'(fpVal), 32'hF);
    checkOutput("stop8_val", 32'(fp8Val), 32'h0F);
    checkOutput("stop_norom", 32'(romCs1), 0);
    checkOutput("stop_nostart", fsCyc, 0);

    // Group 1 select, then phrase 1 on mask 1
    applyStimulus(8'h01);
    runWindow(4, 1'b0);
    checkOutput("grp_nostop8", 32'(anyStop8), 0);
    checkOutput("grp_nostop4", fpCyc, 0);
    applyStimulus(8'h81);
    applyStimulus(8'h10);
    runWindow(20, 1'b0);
    checkOutput("g1_cycle", fsCyc, 13);
    checkOutput("g1_start8", 32'(fs8Val), 32'h10);
    checkOutput("g1_start4", 32'(fsVal), 32'h01);
    checkOutput("g1_saddr8_4", 32'(start_addr8[4*AW +: AW]), 32'h40);
    checkOutput("g1_eaddr8_4", 32'(end_addr8[4*AW +: AW]), 32'h80);
    checkOutput("g1_saddr8_1", 32'(start_addr8[1*AW +: AW]), 32'h100);
    checkOutput("g1_saddr4_0", 32'(start_addr4[0 +: AW]), 32'h40);

    // end < start: nothing issued
    applyStimulus(8'h82);
    applyStimulus(8'h2A);
    runWindow(20, 1'b0);
    checkOutput("endlt_nostart", fsCyc, 0);
    checkOutput("endlt_saddr1", 32'(start_addr4[1*AW +: AW]), 32'h100);
    checkOutput("endlt_att1", 32'(att4[7:4]), 32'hF);
    checkOutput("endlt_idle", 32'(cmd_busy4), 0);

    // Busy target channel
    busy4 = 4'b0010; busy8 = 8'h02;
    applyStimulus(8'h83);
    applyStimulus(8'h23);
    runWindow(20, 1'b0);
`ifdef JT6295_RETRIG_EN
    checkOutput("retrig_stopcyc", fpCyc, 13);
    checkOutput("retrig_stopval", 32'(fpVal), 32'h02);
    checkOutput("retrig_startcyc", fsCyc, 14);
    checkOutput("retrig_startval", 32'(fsVal), 32'h02);
    checkOutput("retrig_cmdbusy", 32'(cbAtStart), 1);
    checkOutput("retrig_saddr1", 32'(start_addr4[1*AW +: AW]), 32'h500);
    checkOutput("retrig_att1", 32'(att4[7:4]), 32'h3);
`else
    checkOutput("busy_nostart", fsCyc, 0);
    checkOutput("busy_nostop", fpCyc, 0);
    checkOutput("busy_saddr1", 32'(start_addr4[1*AW +: AW]), 32'h100);
    checkOutput("busy_att1", 32'(att4[7:4]), 32'hF);
`endif
    checkOutput("busy_idle", 32'(cmd_busy4), 0);
    busy4 = '0; busy8 = '0;

    // rom_ok low for three cycles on header byte 2
    applyStimulus(8'h85);
    applyStimulus(8'h4C);
    runWindow(20, 1'b1);
    checkOutput("wait_cycle", fsCyc, 16);
    checkOutput("wait_start4", 32'(fsVal), 32'h04);
    checkOutput("wait_saddr2", 32'(start_addr4[2*AW +: AW]), 32'h100);
    checkOutput("wait_att2", 32'(att4[11:8]), 32'hC);

    // Reset in the middle of a fetch
    applyStimulus(8'h85);
    applyStimulus(8'h8F);
    repeat (5) @(negedge clk);
    checkOutput("midf_romcs", 32'(rom_cs4), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midf_rst_romcs", 32'(rom_cs4), 0);
    checkOutput("midf_rst_cmdbusy", 32'(cmd_busy4), 0);
    checkOutput("midf_rst_saddr", 32'(start_addr4[31:0]), 0);
    checkOutput("midf_rst_att", 32'(att4), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    runWindow(20, 1'b0);
    checkOutput("midf_nostart", fsCyc, 0);
    checkOutput("midf_nostop", fpCyc, 0);
    checkOutput("midf_idle", 32'(cmd_busy4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt6295_vctrl.md
# jt6295_vctrl

Parametrised command/voice controller for the jt6295 ADPCM core, the successor of the fixed 4-channel controller. It decodes MSM6295-format CPU writes, fetches phrase start/end addresses from the ROM phrase table, and issues per-channel start/stop pulses with attenuation to the serial ADPCM engine. It generalises channel count (up to 8, via a channel-group register) and ROM address width, and adds a ROM handshake with wait states plus an optional retrigger mode.

## Interface
Parameters:
- CH, 4, number of voices; legal values 1..8.
- AW, 18, ROM address width; legal values 18..24.
- GW, derived, group width = (CH>4) ? 1 : 0 (minimum 1 bit stored).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- wrn  in  1  CPU write strobe, active low.
- din  in  8  CPU write data.
- busy  in  CH  per-channel playing flag from the serial engine.
- start  out  CH  one-cycle start pulse per channel.
- stop  out  CH  one-cycle stop pulse per channel.
- start_addr  out  CH*AW  packed start addresses, channel 0 in LSBs.
- end_addr  out  CH*AW  packed end addresses.
- att  out  CH*4  packed attenuation codes, raw 4-bit.
- rom_cs  out  1  ROM request.
- rom_addr  out  AW  ROM byte address.
- rom_data  in  8  ROM byte.
- rom_ok  in  1  ROM data valid for current rom_addr.
- cmd_busy  out  1  high while a phrase command is pending (WAIT_CH, FETCH, ISSUE).

## Operation
- Write detection: din latched every cycle wrn=0; command executed on first cycle wrn=1 after a low (decode cycle). Back-to-back writes need ≥1 clk high between them.
- Phrase byte (din[7]=1): phrase P=din[6:0] latched, state IDLE→WAIT_CH.
- In WAIT_CH, next write is the channel byte: mask M=din[7:4], attenuation A=din[3:0]; selected channels are G*4+i for M[i]=1, indexes ≥CH discarded. State→FETCH.
- Stop byte (din[7]=0, in IDLE or FETCH): G←din[2:0] truncated to GW bits (forced 0 when CH≤4); stop pulse on channels G*4+i for din[3+i]=1. Applied in the cycle after decode regardless of state. A stop byte in WAIT_CH is taken as the channel byte.
- Phrase byte received in FETCH/ISSUE is dropped.
- FETCH: rom_cs=1, rom_addr=P*8+k, k=0..5. Byte k accepted on first cycle rom_ok=1 that is ≥1 cycle after rom_addr changed; then k increments. Start = {b0,b1,b2}[AW-1:0], end = {b3,b4,b5}[AW-1:0], big-endian.
- ISSUE (one cycle): for each selected channel: if end<start, nothing; else if busy=1 the start is ignored (default); otherwise start_addr/end_addr/att updated and start pulsed. Then IDLE, rom_cs=0.
- States: IDLE, WAIT_CH, FETCH, ISSUE.

## Timing
- Reset: start, stop, start_addr, end_addr, att, rom_cs, rom_addr, cmd_busy all 0; state IDLE; G=0; k=0. Reset mid-FETCH abandons the command with no pulses.
- Stop latency: stop pulse 1 clk after decode cycle, width 1.
- Start latency with rom_ok tied high: decode at cycle 0, FETCH from cycle 1, bytes sampled cycles 2,4,…,12, start pulse and updated outputs at cycle 13, width 1. Each rom_ok wait cycle adds 1.
- Stop and start to the same channel in the same cycle: start wins; stop suppressed.
- start_addr/end_addr/att change only in ISSUE cycle; held otherwise.

## Configuration
- JT6295_RETRIG_EN defined: a start to a busy channel is accepted: stop pulsed on that channel in the ISSUE cycle, outputs updated, start pulsed next cycle (latency +1, cmd_busy held through it).
- Undefined: busy channels ignore starts (MSM6295 behaviour).

## Structure
- Package jt6295_pkg: state enum, localparams TBL_BYTES=8, HDR_BYTES=6, ATT_W=4, GRP_CH=4.
- Sub-module jt6295_wrdet: wrn edge detector with din latch, outputs one-cycle cmd_stb and cmd_data.

## Test plan
- CH=4, rom_ok=1, phrase 0x85 then 0x2F, table at 0x28..0x2D = 00 01 00 00 02 00 -> start[1] pulse cycle 13, start_addr1=0x00100, end_addr1=0x00200, att1=0xF.
- Stop byte 0x78 -> stop=4'hF one cycle after decode, no ROM access.
- CH=8: stop 0x01 (G=1), then phrase 0x81 + 0x10 -> start[4] only.
- Entry with end<start, or target channel busy -> no start, outputs unchanged; with JT6295_RETRIG_EN busy case -> stop then start on consecutive cycles.
- rom_ok low 3 cycles on byte 2 -> start pulse at cycle 16; rst during FETCH -> all outputs 0, no pulse.
